// File: rtl/hcm_readout_sequencer_pkg.sv
// rtl/hcm_readout_sequencer_pkg.sv - shared HCM geometry defaults and sequencer state type
//
// Purpose: HCM geometry shared with the rest of HCMPP (row count, row index width,
// row width) plus the readout sequencer's default window sizes, read latency and
// output buffer depth. The sequencer FSM state type is defined here as well.
package hcm_readout_sequencer_pkg;

    localparam int NROWS_HCM        = 65536;
    localparam int ROWINDEXBITS_HCM = 16;
    localparam int NCOLS_HCM        = 64;

    localparam int HEAD_ROWS_HCM    = 50;
    localparam int TAIL_ROWS_HCM    = 50;
    localparam int RD_LAT_HCM       = 2;
    localparam int FIFO_DEPTH_HCM   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_TAIL  = 3'd2,
        ST_FULL  = 3'd3,
        ST_DRAIN = 3'd4
    } seqState_t;

endpackage

// File: rtl/hcm_readout_fifo.sv
// rtl/hcm_readout_fifo.sv - synchronous output buffer for returned HCM rows
//
// Purpose: single-clock FIFO holding {row index, row data} entries between the
// HCM return path and the downstream stream. Head entry is presented
// combinationally on popData; simultaneous push and pop are legal at any
// fill level, including full, because the write lands in the slot being freed.
// Ports:
//   clk, reset   clock, asynchronous active-low reset (pointers and count)
//   push         write pushData this cycle (caller guarantees no overflow)
//   pushData     entry to write
//   pop          discard head entry this cycle (caller guarantees not empty)
//   popData      head entry
//   count        number of stored entries, 0..DEPTH
//   empty        count == 0
module hcm_readout_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign popData = mem[rdPtr];
    assign empty   = (count == '0);

endmodule

// File: rtl/hcm_readout_sequencer.sv
// rtl/hcm_readout_sequencer.sv - HCM read-side master streaming head/tail or full row dumps
//
// Purpose: on start, reads HCM rows (head window then tail window, or every row),
// tracks each read through an RD_LAT-deep delay line, captures the returned row,
// flags index mismatches and streams the rows out through a small FIFO.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, fullDump             begin a pass when idle; fullDump selects all rows
//   idle, passDone, idxError    status: idle, end-of-pass pulse, sticky index fault
//   readRow, rowToRead          HCM read strobe and address
//   hcmBusy                     HCM cannot accept a read this cycle
//   rowPassed, rowReadOutput    HCM returned index and data, RD_LAT after readRow
//   outValid, outReady          output stream handshake
//   outRow, outData             output stream entry
module hcm_readout_sequencer
    import hcm_readout_sequencer_pkg::*;
#(
    parameter int NROWS      = NROWS_HCM,
    parameter int ROWIDXW    = ROWINDEXBITS_HCM,
    parameter int NCOLS      = NCOLS_HCM,
    parameter int HEAD_ROWS  = HEAD_ROWS_HCM,
    parameter int TAIL_ROWS  = TAIL_ROWS_HCM,
    parameter int RD_LAT     = RD_LAT_HCM,
    parameter int FIFO_DEPTH = FIFO_DEPTH_HCM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fullDump,
    output logic               idle,
    output logic               passDone,
    output logic               idxError,
    output logic               readRow,
    output logic [ROWIDXW-1:0] rowToRead,
    input  logic               hcmBusy,
    input  logic [ROWIDXW-1:0] rowPassed,
    input  logic [NCOLS-1:0]   rowReadOutput,
    output logic               outValid,
    input  logic               outReady,
    output logic [ROWIDXW-1:0] outRow,
    output logic [NCOLS-1:0]   outData
);

    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int OCCW = CNTW + 1;

    // When the windows cover the whole memory, a windowed pass degenerates
    // into a single sweep so that no row is read twice.
    localparam bit OVERLAP = (HEAD_ROWS + TAIL_ROWS) >= NROWS;

    localparam logic [ROWIDXW-1:0] HEAD_LAST  = ROWIDXW'(HEAD_ROWS - 1);
    localparam logic [ROWIDXW-1:0] TAIL_FIRST = ROWIDXW'(NROWS - TAIL_ROWS);
    localparam logic [ROWIDXW-1:0] LAST_ROW   = ROWIDXW'(NROWS - 1);

    seqState_t           state;
    seqState_t           stateNext;
    logic [ROWIDXW-1:0]  addr;
    logic [ROWIDXW-1:0]  addrNext;

    logic [RD_LAT-1:0]   dlValid;
    logic [ROWIDXW-1:0]  dlIdx [RD_LAT];

    logic [CNTW-1:0]     fifoCount;
    logic                fifoEmpty;
    logic [ROWIDXW+NCOLS-1:0] fifoHead;
    logic                push;
    logic                pop;

    logic [OCCW-1:0]     inFlight;
    logic [OCCW-1:0]     occupancy;
    logic                canIssue;

    // Reads still in the HCM pipeline already own a FIFO slot, so counting them
    // with the stored entries keeps the FIFO from ever overflowing.
    always_comb begin
        inFlight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inFlight = inFlight + OCCW'(dlValid[i]);
        end
        occupancy = OCCW'(fifoCount) + inFlight;
        canIssue  = !hcmBusy && (occupancy < OCCW'(FIFO_DEPTH));
    end

    always_comb begin
        stateNext = state;
        addrNext  = addr;
        readRow   = 1'b0;
        passDone  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    addrNext  = '0;
                    stateNext = (fullDump || OVERLAP) ? ST_FULL : ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (canIssue) begin
                    readRow = 1'b1;
                    if (addr == HEAD_LAST) begin
                        addrNext  = TAIL_FIRST;
                        stateNext = ST_TAIL;
                    end else begin
                        addrNext = addr + ROWIDXW'(1);
                    end
                end
            end
            ST_TAIL, ST_FULL: begin
                if (canIssue) begin
                    readRow = 1'b1;
                    // Compare rather than rely on overflow: the counter parks on the last row.
                    if (addr == LAST_ROW) begin
                        stateNext = ST_DRAIN;
                    end else begin
                        addrNext = addr + ROWIDXW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (inFlight == '0 && fifoEmpty) begin
                    passDone  = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else begin
            state <= stateNext;
            addr  <= addrNext;
        end
    end

    // Delay line mirrors the HCM read latency; its tail marks the cycle the
    // matching row is on rowPassed/rowReadOutput.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dlValid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dlIdx[i] <= '0;
            end
        end else begin
            dlValid[0] <= readRow;
            dlIdx[0]   <= addr;
            for (int i = 1; i < RD_LAT; i++) begin
                dlValid[i] <= dlValid[i-1];
                dlIdx[i]   <= dlIdx[i-1];
            end
        end
    end

    assign push = dlValid[RD_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idxError <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            idxError <= 1'b0;
        end else if (push && (rowPassed != dlIdx[RD_LAT-1])) begin
            idxError <= 1'b1;
        end
    end

    hcm_readout_fifo #(
        .WIDTH (ROWIDXW + NCOLS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData ({rowPassed, rowReadOutput}),
        .pop      (pop),
        .popData  (fifoHead),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

    assign outValid  = !fifoEmpty;
    assign pop       = outValid && outReady;
    assign outRow    = fifoHead[ROWIDXW+NCOLS-1:NCOLS];
    assign outData   = fifoHead[NCOLS-1:0];
    assign rowToRead = addr;
    assign idle      = (state == ST_IDLE) && fifoEmpty;

endmodule

// File: tb/tb_hcm_readout_sequencer.sv
// tb/tb_hcm_readout_sequencer.sv - directed scoreboard bench for hcm_readout_sequencer
module tb_hcm_readout_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic fullDump;
    logic hcmBusy;
    logic outReady;
    logic faultOn;

    // Instance A: default geometry (65536 rows, 50 + 50 window)
    logic        startA, idleA, passDoneA, idxErrorA, readRowA, outValidA;
    logic [15:0] rowToReadA, rowPassedA, outRowA;
    logic [63:0] rowReadOutputA, outDataA;
    logic [15:0] pipeA [2];

    // Instance B: 64 rows with overlapping 40 + 40 windows
    logic        startB, idleB, passDoneB, idxErrorB, readRowB, outValidB;
    logic [5:0]  rowToReadB, rowPassedB, outRowB;
    logic [7:0]  rowReadOutputB, outDataB;
    logic [5:0]  pipeB [2];

    hcm_readout_sequencer dutA (
        .clk(clk), .reset(reset), .start(startA), .fullDump(fullDump),
        .idle(idleA), .passDone(passDoneA), .idxError(idxErrorA),
        .readRow(readRowA), .rowToRead(rowToReadA), .hcmBusy(hcmBusy),
        .rowPassed(rowPassedA), .rowReadOutput(rowReadOutputA),
        .outValid(outValidA), .outReady(outReady), .outRow(outRowA), .outData(outDataA)
    );

    hcm_readout_sequencer #(
        .NROWS(64), .ROWIDXW(6), .NCOLS(8), .HEAD_ROWS(40), .TAIL_ROWS(40),
        .RD_LAT(2), .FIFO_DEPTH(8)
    ) dutB (
        .clk(clk), .reset(reset), .start(startB), .fullDump(fullDump),
        .idle(idleB), .passDone(passDoneB), .idxError(idxErrorB),
        .readRow(readRowB), .rowToRead(rowToReadB), .hcmBusy(hcmBusy),
        .rowPassed(rowPassedB), .rowReadOutput(rowReadOutputB),
        .outValid(outValidB), .outReady(outReady), .outRow(outRowB), .outData(outDataB)
    );

    // Behavioural HCM: the row addressed in cycle t is returned in cycle t+2,
    // data equal to the row index; optional index fault on row 7.
    always @(posedge clk) begin
        pipeA[0] <= rowToReadA;
        pipeA[1] <= pipeA[0];
        pipeB[0] <= rowToReadB;
        pipeB[1] <= pipeB[0];
    end
    assign rowPassedA     = (faultOn && pipeA[1] == 16'd7) ? 16'd8 : pipeA[1];
    assign rowReadOutputA = {48'd0, pipeA[1]};
    assign rowPassedB     = pipeB[1];
    assign rowReadOutputB = {2'b00, pipeB[1]};

    int vectors = 0;
    int miscompares = 0;
    int expRow[$];
    int expData[$];
    bit useB;
    int issues, passDones, issuesSnap;
    bit holdValid;
    logic [63:0] holdRow, holdData;

    logic        s_readRow, s_outValid, s_passDone, s_idle, s_idxError;
    logic [63:0] s_outRow, s_outData, s_rowToRead;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample the selected DUT at the falling edge, run the
    // scoreboard and protocol checks, then return just after the rising edge.
    task automatic cyc();
        int er, ed;
        @(negedge clk);
        if (useB) begin
            s_readRow = readRowB; s_outValid = outValidB; s_passDone = passDoneB;
            s_idle = idleB; s_idxError = idxErrorB; s_outRow = 64'(outRowB);
            s_outData = 64'(outDataB); s_rowToRead = 64'(rowToReadB);
        end else begin
            s_readRow = readRowA; s_outValid = outValidA; s_passDone = passDoneA;
            s_idle = idleA; s_idxError = idxErrorA; s_outRow = 64'(outRowA);
            s_outData = outDataA; s_rowToRead = 64'(rowToReadA);
        end
        if (s_readRow) issues++;
        if (s_passDone) passDones++;
        if (hcmBusy) chk("readRowWhileBusy", 64'(s_readRow), 64'd0);
        if (holdValid) begin
            chk("holdValid", 64'(s_outValid), 64'd1);
            chk("holdRow", s_outRow, holdRow);
            chk("holdData", s_outData, holdData);
        end
        holdValid = s_outValid && !outReady;
        holdRow   = s_outRow;
        holdData  = s_outData;
        if (s_outValid && outReady) begin
            chk("entryExpected", 64'(expRow.size() != 0), 64'd1);
            if (expRow.size() != 0) begin
                er = expRow.pop_front();
                ed = expData.pop_front();
                chk("outRow", s_outRow, 64'(er));
                chk("outData", s_outData, 64'(ed));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input bit b, input bit fd);
        fullDump = fd;
        issues = 0;
        passDones = 0;
        if (b) startB = 1'b1; else startA = 1'b1;
        cyc();
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic pushWindow(input bit fault);
        for (int r = 0; r < 50; r++) begin
            expRow.push_back((fault && r == 7) ? 8 : r);
            expData.push_back(r);
        end
        for (int r = 65486; r < 65536; r++) begin
            expRow.push_back(r);
            expData.push_back(r);
        end
    endtask

    task automatic pushAll64();
        for (int r = 0; r < 64; r++) begin
            expRow.push_back(r);
            expData.push_back(r);
        end
    endtask

    // k = 0 is the first cycle after the start cycle.
    task automatic runPass(input int readyAt, input int busyLo, input int busyHi,
                           input int startAt, input int bound);
        int k = 0;
        while (passDones == 0 && k < bound) begin
            outReady = (k >= readyAt);
            hcmBusy  = (k >= busyLo && k <= busyHi);
            if (k == readyAt) issuesSnap = issues;
            if (k == startAt) begin
                if (useB) startB = 1'b1; else startA = 1'b1;
            end
            cyc();
            startA = 1'b0;
            startB = 1'b0;
            if (k == 0) begin
                chk("firstReadLatency", 64'(s_readRow), 64'd1);
                chk("firstRow", s_rowToRead, 64'd0);
                chk("idleDeassert", 64'(s_idle), 64'd0);
            end
            if (k == 2) chk("outValidNotEarly", 64'(s_outValid), 64'd0);
            if (k == 3) chk("outValidLatency", 64'(s_outValid), 64'd1);
            if (busyLo >= 0 && k == busyHi + 1) begin
                chk("resumeRead", 64'(s_readRow), 64'd1);
                chk("resumeRow", s_rowToRead, 64'(busyLo));
            end
            k++;
        end
        hcmBusy  = 1'b0;
        outReady = 1'b1;
        cyc();
        chk("passDoneOnce", 64'(passDones), 64'd1);
        chk("idleAfter", 64'(s_idle), 64'd1);
        chk("queueDrained", 64'(expRow.size()), 64'd0);
    endtask

    initial begin
        int k;
        reset = 1'b0; startA = 1'b0; startB = 1'b0; fullDump = 1'b0;
        hcmBusy = 1'b0; outReady = 1'b1; faultOn = 1'b0; useB = 1'b0;
        holdValid = 1'b0; issues = 0; passDones = 0; issuesSnap = 0;
        repeat (3) cyc();
        chk("rstIdle", 64'(idleA), 64'd1);
        chk("rstReadRow", 64'(readRowA), 64'd0);
        chk("rstRowToRead", 64'(rowToReadA), 64'd0);
        chk("rstOutValid", 64'(outValidA), 64'd0);
        chk("rstPassDone", 64'(passDoneA), 64'd0);
        chk("rstIdxError", 64'(idxErrorA), 64'd0);
        reset = 1'b1;
        cyc();

        // 1: windowed pass, no backpressure
        doStart(1'b0, 1'b0);
        pushWindow(1'b0);
        runPass(0, -1, -1, -1, 400);
        chk("t1Issues", 64'(issues), 64'd100);
        chk("t1IdxError", 64'(s_idxError), 64'd0);

        // 2: downstream stalled for 40 cycles
        doStart(1'b0, 1'b0);
        pushWindow(1'b0);
        runPass(40, -1, -1, -1, 400);
        chk("t2IssuesStalled", 64'(issuesSnap), 64'd8);
        chk("t2Issues", 64'(issues), 64'd100);

        // 3: HCM busy for pass cycles 5..14
        doStart(1'b0, 1'b0);
        pushWindow(1'b0);
        runPass(0, 5, 14, -1, 400);
        chk("t3Issues", 64'(issues), 64'd100);

        // 4: HCM returns the wrong index for row 7
        faultOn = 1'b1;
        doStart(1'b0, 1'b0);
        pushWindow(1'b1);
        runPass(0, -1, -1, -1, 400);
        chk("t4IdxErrorSticky", 64'(s_idxError), 64'd1);
        faultOn = 1'b0;

        // 5: next start clears idxError; reset lands mid-pass
        doStart(1'b0, 1'b0);
        pushWindow(1'b0);
        cyc();
        chk("t5IdxErrorCleared", 64'(s_idxError), 64'd0);
        k = 0;
        while (issues < 30 && k < 200) begin
            cyc();
            k++;
        end
        chk("t5Reached30", 64'(issues), 64'd30);
        reset = 1'b0;
        #1;
        chk("t5RstReadRow", 64'(readRowA), 64'd0);
        chk("t5RstRowToRead", 64'(rowToReadA), 64'd0);
        chk("t5RstOutValid", 64'(outValidA), 64'd0);
        chk("t5RstIdle", 64'(idleA), 64'd1);
        chk("t5RstPassDone", 64'(passDoneA), 64'd0);
        expRow.delete();
        expData.delete();
        holdValid = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        doStart(1'b0, 1'b0);
        pushWindow(1'b0);
        runPass(0, -1, -1, -1, 400);
        chk("t5Issues", 64'(issues), 64'd100);
        chk("t5IdxError", 64'(s_idxError), 64'd0);

        // 6: overlapping windows on a 64-row memory, stray start mid-pass
        useB = 1'b1;
        cyc();
        doStart(1'b1, 1'b0);
        pushAll64();
        runPass(0, -1, -1, 10, 400);
        chk("t6Issues", 64'(issues), 64'd64);
        doStart(1'b1, 1'b1);
        pushAll64();
        runPass(0, -1, -1, -1, 400);
        chk("t6FullIssues", 64'(issues), 64'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
